// File: rtl/peripheral_mpram_req_ctrl.sv
// MPRAM request controller: valid/ready requests to RAM strobes,
// in-order responses through a credit-guarded FIFO.
module peripheral_mpram_req_ctrl #(
  parameter int ADDR_MSB  = 7,
  parameter int MEM_SIZE  = 256,
  parameter int RSP_DEPTH = 4
) (
  input  logic                ram_clk,
  input  logic                ram_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_be,
  input  logic [ADDR_MSB-1:0] req_addr,
  input  logic [15:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [15:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_MSB-1:0] ram_addr,
  output logic [15:0]         ram_din,
  input  logic [15:0]         ram_dout,
  output logic                ram_cen,
  output logic [1:0]          ram_wen
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int unsigned WORDS = MEM_SIZE / 2;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } inflight_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  logic          accept;
  logic          pop;
  logic          push;
  logic          err;
  logic [CW-1:0] used_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  inflight_t     fl_q;
  rsp_t          push_ent;
  rsp_t          head;
  rsp_t          fifo_q [RSP_DEPTH];

  assign req_ready = !ram_rst && (used_q < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign err       = 32'(req_addr) >= WORDS;

  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = '0;
    ram_din  = '0;
    if (accept) begin
      ram_addr = req_addr;
      ram_din  = req_wdata;
      if (!err) begin
        ram_cen = !(!req_we || (req_be != 2'b00));
        if (req_we) ram_wen = ~req_be;
      end
    end
  end

  // read data is only meaningful one cycle after a non-error read
  always_comb begin
    push           = fl_q.valid;
    push_ent.err   = fl_q.err;
    push_ent.rdata = '0;
    if (!fl_q.we && !fl_q.err) push_ent.rdata = ram_dout;
  end

  assign rsp_valid = !ram_rst && (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign rsp_rdata = rsp_valid ? head.rdata : 16'h0000;
  assign rsp_err   = rsp_valid && head.err;

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      used_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      fl_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      fl_q.valid <= accept;
      fl_q.we    <= req_we;
      fl_q.err   <= err;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge ram_clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_ent;
  end

  // credits cover every entry, so a full FIFO can never see a lone push
  a_no_overflow: assert property (
    @(posedge ram_clk) disable iff (ram_rst)
    !(push && (cnt_q == CW'(RSP_DEPTH)) && !pop)
  );

  a_used_range: assert property (
    @(posedge ram_clk) disable iff (ram_rst)
    used_q <= CW'(RSP_DEPTH)
  );

endmodule

// File: tb/tb_peripheral_mpram_req_ctrl.sv
// Randomized bench for peripheral_mpram_req_ctrl against a queue-based
// response model and a shadow memory.
module tb_peripheral_mpram_req_ctrl;

  localparam int AW    = 7;
  localparam int MS    = 200;
  localparam int D     = 4;
  localparam int WORDS = MS / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_be = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [15:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [15:0]   ram_dout = '0;
  logic          ram_cen;
  logic [1:0]    ram_wen;

  always #5 clk = ~clk;

  peripheral_mpram_req_ctrl #(
    .ADDR_MSB (AW),
    .MEM_SIZE (MS),
    .RSP_DEPTH(D)
  ) dut (
    .ram_clk  (clk),
    .ram_rst  (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_be   (req_be),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen)
  );

  logic [15:0] ram [128];

  always @(posedge clk) begin
    if (!ram_cen) begin
      if (ram_wen == 2'b11) begin
        ram_dout <= ram[ram_addr];
      end else begin
        if (!ram_wen[0]) ram[ram_addr][7:0]  <= ram_din[7:0];
        if (!ram_wen[1]) ram[ram_addr][15:8] <= ram_din[15:8];
      end
    end
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic [15:0] shadow [128];
  exp_t        q [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          used_m   = 0;
  int          n_acc    = 0;
  int          n_pop    = 0;
  logic        last_acc = 1'b0;
  logic        rst_d    = 1'b0;
  logic [15:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic       rdy;
    logic       e;
    logic       acc;
    logic       vld;
    logic       pop;
    logic [1:0] wen_e;
    exp_t       ent;
    @(negedge clk);
    cyc++;
    rdy   = !rst && (used_m < D);
    e     = int'(req_addr) >= WORDS;
    acc   = req_valid && rdy;
    vld   = !rst && (q.size() > 0) && (q[0].acc + 2 <= cyc);
    wen_e = (acc && req_we && !e) ? ~req_be : 2'b11;
    chk("req_ready", req_ready, rdy);
    chk("rsp_valid", rsp_valid, vld);
    chk("ram_cen", ram_cen, !(acc && !e && (!req_we || req_be != 2'b00)));
    chk("ram_wen", ram_wen, wen_e);
    chk("ram_addr", ram_addr, acc ? req_addr : '0);
    chk("ram_din", ram_din, acc ? req_wdata : 16'h0);
    if (vld) begin
      chk("rsp_rdata", rsp_rdata, q[0].rdata);
      chk("rsp_err", rsp_err, q[0].err);
    end
    if (rst || rst_d) begin
      chk("rst_rdata", rsp_rdata, 16'h0);
      chk("rst_err", rsp_err, 1'b0);
    end
    pop = vld && rsp_ready;
    if (pop) begin
      last_rdata = q[0].rdata;
      last_err   = q[0].err;
      last_lat   = cyc - q[0].acc;
      void'(q.pop_front());
      n_pop++;
    end
    if (acc) begin
      ent.err   = e;
      ent.acc   = cyc;
      ent.rdata = (!req_we && !e) ? shadow[req_addr] : 16'h0;
      if (req_we && !e) begin
        if (req_be[0]) shadow[req_addr][7:0]  = req_wdata[7:0];
        if (req_be[1]) shadow[req_addr][15:8] = req_wdata[15:8];
      end
      q.push_back(ent);
      n_acc++;
    end
    used_m = used_m + int'(acc) - int'(pop);
    if (rst) begin
      q.delete();
      used_m = 0;
    end
    rst_d    = rst;
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic we, input logic [1:0] be,
                      input int addr, input logic [15:0] wd);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = AW'(addr);
    req_wdata = wd;
    forever begin
      step();
      if (last_acc) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int p0;
    int a0;
    for (int i = 0; i < 128; i++) begin
      ram[i]    = 16'($urandom);
      shadow[i] = ram[i];
    end
    #1;
    idle(3);
    rst = 1'b0;
    idle(2);

    send(1'b1, 2'b11, 5, 16'hA55A);
    idle(3);
    chk("wr_lat", last_lat, 2);
    chk("wr_rdata", last_rdata, 16'h0);
    chk("wr_err", last_err, 1'b0);

    send(1'b0, 2'b11, 5, 16'h0);
    idle(3);
    chk("rd_lat", last_lat, 2);
    chk("rd_a55a", last_rdata, 16'hA55A);

    send(1'b1, 2'b01, 5, 16'h1234);
    idle(3);
    send(1'b0, 2'b11, 5, 16'h0);
    idle(3);
    chk("rd_a534", last_rdata, 16'hA534);

    send(1'b0, 2'b11, 100, 16'h0);
    idle(3);
    chk("oor_err", last_err, 1'b1);
    chk("oor_rdata", last_rdata, 16'h0);
    send(1'b0, 2'b11, 99, 16'h0);
    idle(3);
    chk("edge_err", last_err, 1'b0);

    rsp_ready = 1'b0;
    a0        = n_acc;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'($urandom_range(0, 99));
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) req_addr = AW'($urandom_range(0, 99));
    end
    req_valid = 1'b0;
    chk("bp_acc", n_acc - a0, 4);
    chk("bp_ready", req_ready, 1'b0);
    p0        = n_pop;
    rsp_ready = 1'b1;
    step();
    chk("bp_ready_back", req_ready, 1'b1);
    idle(6);
    chk("bp_pops", n_pop - p0, 4);

    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = AW'(10 + i);
      step();
    end
    req_valid = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    p0        = n_pop;
    send(1'b0, 2'b11, 20, 16'h0);
    idle(4);
    chk("mid_rst_pops", n_pop - p0, 1);
    chk("mid_rst_data", last_rdata, shadow[20]);

    for (int i = 0; i < 3000; i++) begin
      if (!(req_valid && !last_acc)) begin
        req_valid = ($urandom % 4) != 0;
        req_we    = 1'($urandom);
        req_be    = 2'($urandom);
        req_addr  = (($urandom % 8) == 0) ? AW'($urandom_range(100, 127))
                                           : AW'($urandom_range(0, 99));
        req_wdata = 16'($urandom);
      end
      rsp_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 400) == 0;
      step();
    end

    rst       = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(10);
    chk("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peripheral_mpram_req_ctrl.md
Name: peripheral_mpram_req_ctrl

Overview:
- Upstream request controller for the MPRAM single-port 16-bit RAM (active-low chip enable, active-low byte write enables, 1-cycle read latency).
- Converts a valid/ready request channel into RAM control strobes. Captures read data one cycle after the access and returns every request (read or write) as a response on a valid/ready channel.
- Flow control is credit-based so the response FIFO can never overflow.
- Out-of-range word addresses are rejected with an error response and no RAM access.

Parameters:
- ADDR_MSB, 7, width of the word address bus (req_addr and ram_addr are [ADDR_MSB-1:0]).
- MEM_SIZE, 256, memory size in bytes; valid word addresses are 0 .. MEM_SIZE/2-1.
- RSP_DEPTH, 4, response FIFO entries and total outstanding-request credits; power of two, minimum 2.

Ports:
- ram_clk  in  1  clock, all logic on rising edge.
- ram_rst  in  1  synchronous reset, active high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  2  byte enables, active high; [0] = low byte, [1] = high byte.
- req_addr  in  ADDR_MSB  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_rdata  out  16  read data; 0 for writes and errors.
- rsp_err  out  1  1 = address out of range.
- ram_addr  out  ADDR_MSB  to RAM address.
- ram_din  out  16  to RAM write data.
- ram_dout  in  16  from RAM read data.
- ram_cen  out  1  RAM chip enable, active low.
- ram_wen  out  2  RAM byte write enables, active low.

Behaviour:
- Clocking and reset:
  - One clock (ram_clk). Reset ram_rst is synchronous and active-high.
  - While ram_rst=1 and in the cycle after: req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0.
- Handshakes:
  - accept = req_valid & req_ready.
  - pop = rsp_valid & rsp_ready.
  - Request fields must be held stable while req_valid=1 and req_ready=0.
  - Responses are returned strictly in request order.
- Credits:
  - Counter used, range 0..RSP_DEPTH. +1 on accept, -1 on pop; unchanged when both occur in the same cycle.
  - req_ready = !ram_rst & (used < RSP_DEPTH). It is registered-state only and has no combinational path from rsp_ready.
- Range check: err = (req_addr >= MEM_SIZE/2).
- RAM drive (combinational from the request in the accept cycle; RAM samples at the end of that cycle):
  - Read: ram_cen=0 only when accept & !err & (!req_we | req_be!=0).
  - ram_wen = (accept & req_we & !err) ? ~req_be : 2'b11.
  - ram_addr = req_addr and ram_din = req_wdata when accept, else 0.
  - A write with req_be=00 performs no RAM access and still returns an OK response.
- Pipeline:
  - Accept in cycle N loads an in-flight register {valid, we, err} at the end of N.
  - In cycle N+1, ram_dout is valid. The entry {rdata, err} is pushed into the FIFO at the end of N+1:
    - rdata = ram_dout for a non-error read, else 0.
    - err = the registered err.
  - rsp_valid is asserted from cycle N+2 at the earliest (request-to-response latency 2 cycles).
- Throughput:
  - One request per cycle sustained when rsp_ready=1 and RSP_DEPTH>=3.
  - With RSP_DEPTH=2, at most 2 requests per 3 cycles.
- FIFO:
  - Fall-through-free. rsp_rdata and rsp_err come from the head register.
  - A push and a pop in the same cycle are both performed.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by construction; the implementation shall include an assertion for it.
- Backpressure: when rsp_ready=0, the response is held stable, with rsp_valid, rsp_rdata and rsp_err unchanged, until popped.
- Reset mid-operation: the in-flight request and all FIFO entries are discarded and used returns to 0. No response is issued for dropped requests.

Test Plan:
- Reset then write addr 0x05, be=11, wdata 0xA55A -> ram_cen=0 and ram_wen=00 in the accept cycle. Response OK, rdata 0x0000, rsp_valid 2 cycles after accept.
- Read addr 0x05 after that write, with the RAM model returning 0xA55A -> rsp_rdata=0xA55A, rsp_err=0, latency 2.
- Write be=01, wdata 0x1234 to addr 0x05, then read -> ram_wen=10 during the write, and the read returns 0xA534.
- MEM_SIZE=200, read addr 100 -> ram_cen stays 1, rsp_err=1, rsp_rdata=0. Read addr 99 is accepted with rsp_err=0.
- rsp_ready held 0 with 6 back-to-back reads, RSP_DEPTH=4 -> exactly 4 accepted, then req_ready=0. After releasing rsp_ready, 4 in-order responses follow and req_ready returns to 1 the cycle after the first pop.
- Assert ram_rst with 1 request in flight and 2 queued -> rsp_valid=0 and used=0 the next cycle. The next read returns only its own data.
